// File: rtl/serv_uart_rx.sv
// 8N1 UART receiver for the servant console line: 2-flop synchronizer, mid-bit
// sampling FSM and a valid/ready output register with frame-error/overrun pulses.
module serv_uart_rx #(
  parameter int clks_per_bit = 556
) (
  input  logic       wb_clk,
  input  logic       wb_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun
);

  if (clks_per_bit < 4 || clks_per_bit > 65535) begin : g_bad_clks_per_bit
    $error("serv_uart_rx: clks_per_bit must be within 4..65535");
  end

  localparam int CW = $clog2(clks_per_bit);
  localparam logic [CW-1:0] HALF_M1 = CW'(clks_per_bit / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(clks_per_bit - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  logic          rx_meta_q;
  logic          rx_s_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          tick;
  logic          done;
  logic          load;

  // Synchronizer idles high so reset never looks like a start bit.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done    = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = HALF_M1;
        end
      end
      S_START: begin
        if (tick) begin
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = FULL_M1;
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          cnt_d   = FULL_M1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STOP: begin
        // Counter is already 0 here, so IDLE is entered with a clean counter.
        if (tick) begin
          if (rx_s_q) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_BREAK: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
    end
  end

  always_ff @(posedge wb_clk) begin
    shift_q <= shift_d;
  end

  // A completed byte may load in the same cycle the previous one is accepted.
  always_comb begin
    load    = done & (~valid_q | i_ready);
    data_d  = load ? shift_q : data_q;
    valid_d = load | (valid_q & ~i_ready);
    ovr_d   = done & valid_q & ~i_ready;
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_serv_uart_rx.sv
// Scoreboard bench for serv_uart_rx at 16 clocks per bit: frames push expected
// events (byte / frame error / overrun with exact cycle), a monitor pops them.
module tb_serv_uart_rx;

  localparam int N   = 16;
  // Line falls after edge e0; sync adds 2 edges, then H + 9N to the stop
  // sample, and the outputs update one edge later: 2 + 1 + 8 + 144 = 155.
  localparam int LAT = 155;
  localparam int KB  = 0;
  localparam int KF  = 1;
  localparam int KO  = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         at;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       ready;
  logic       o_frame_err;
  logic       o_overrun;

  int   cyc;
  int   n_cmp;
  int   n_bad;
  exp_t exp_q[$];

  serv_uart_rx #(.clks_per_bit(N)) dut (
    .wb_clk     (clk),
    .wb_rst_n   (rst_n),
    .i_rx       (rx),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (ready),
    .o_frame_err(o_frame_err),
    .o_overrun  (o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_ev(input int kind, input logic [7:0] data);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind=%0d data=%02h at cycle %0d, required no event",
               kind, data, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == KB && e.data != data) || e.at != cyc) begin
        n_bad++;
        $display("FAIL event: got kind=%0d data=%02h cycle=%0d, required kind=%0d data=%02h cycle=%0d",
                 kind, data, cyc, e.kind, e.data, e.at);
      end
    end
  endtask

  // Monitor: a new byte is presented when o_valid rises or reloads right after an accept.
  initial begin
    logic prev_valid;
    logic prev_acc;
    prev_valid = 1'b0;
    prev_acc   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        prev_acc   = 1'b0;
      end else begin
        if (o_valid && (!prev_valid || prev_acc)) check_ev(KB, o_data);
        if (o_frame_err) check_ev(KF, 8'h00);
        if (o_overrun) check_ev(KO, 8'h00);
        prev_valid = o_valid;
        prev_acc   = o_valid && ready;
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int kind);
    logic [9:0] fr;
    exp_t       e;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        e.kind = kind;
        e.data = b;
        e.at   = cyc + LAT;
        exp_q.push_back(e);
      end
      rx = fr[i];
      repeat (N - 1) @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    rx    = 1'b1;
    ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", 32'(o_data), 32'h00);
    chk("reset_valid", 32'(o_valid), 32'h0);
    chk("reset_ferr", 32'(o_frame_err), 32'h0);
    chk("reset_ovr", 32'(o_overrun), 32'h0);
    rst_n = 1'b1;
    idle(10);

    // Back-to-back frames, no idle gap
    send_frame(8'h55, 1'b1, KB);
    send_frame(8'h00, 1'b1, KB);
    send_frame(8'hFF, 1'b1, KB);
    idle(20);

    // Glitch shorter than the start window, then a good byte
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (5) @(posedge clk);
    #1 rx = 1'b1;
    idle(40);
    send_frame(8'h96, 1'b1, KB);
    idle(20);

    // Framing error followed by a long low line, then recovery
    send_frame(8'h3C, 1'b0, KF);
    idle(100);
    rx = 1'b1;
    idle(20);
    send_frame(8'h81, 1'b1, KB);
    idle(20);

    // Overrun with the consumer stalled
    ready = 1'b0;
    send_frame(8'h12, 1'b1, KB);
    send_frame(8'h34, 1'b1, KO);
    idle(5);
    chk("ovr_hold_valid", 32'(o_valid), 32'h1);
    chk("ovr_hold_data", 32'(o_data), 32'h12);
    ready = 1'b1;
    idle(1);
    ready = 1'b0;
    chk("ovr_accept_clears", 32'(o_valid), 32'h0);
    idle(10);

    // Accept and load in the same cycle
    send_frame(8'h5A, 1'b1, KB);
    idle(10);
    fork
      send_frame(8'hC3, 1'b1, KB);
      begin
        @(posedge clk);
        repeat (LAT - 1) @(posedge clk);
        #1;
        chk("simul_pre_valid", 32'(o_valid), 32'h1);
        chk("simul_pre_data", 32'(o_data), 32'h5A);
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
        chk("simul_post_valid", 32'(o_valid), 32'h1);
        chk("simul_post_data", 32'(o_data), 32'hC3);
      end
    join
    ready = 1'b1;
    idle(20);
    chk("simul_drained", 32'(o_valid), 32'h0);

    // Reset in the middle of a frame with a byte pending
    ready = 1'b0;
    send_frame(8'h6E, 1'b1, KB);
    idle(5);
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (N) @(posedge clk);
    #1 rx = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_data", 32'(o_data), 32'h00);
    chk("midrst_valid", 32'(o_valid), 32'h0);
    chk("midrst_ferr", 32'(o_frame_err), 32'h0);
    chk("midrst_ovr", 32'(o_overrun), 32'h0);
    rst_n = 1'b1;
    ready = 1'b1;
    idle(200);
    send_frame(8'hA5, 1'b1, KB);
    idle(40);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
